// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte stream, instruction-memory write port and loader status
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic                  s_valid;
    logic [7:0]            s_data;
    logic                  s_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  cpu_reset;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [ADDR_WIDTH:0]   words_loaded;

    modport master (
        output start, s_valid, s_data,
        input  s_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, error, words_loaded
    );

    modport slave (
        input  start, s_valid, s_data,
        output s_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, error, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot loader assembling a length-prefixed little-endian byte stream into instruction memory
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input logic          clk,
    input logic          reset,
    imem_loader_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR} state_t;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [1:0]            idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [15:0]           n_full;

    // Every output is decoded from state or taken straight from a register,
    // so s_ready never depends on s_valid.
    assign bus.s_ready      = state_q inside {LEN_LO, LEN_HI, DATA};
    assign bus.busy         = state_q inside {LEN_LO, LEN_HI, DATA, WRITE};
    assign bus.imem_we      = state_q == WRITE;
    assign bus.cpu_reset    = state_q != DONE;
    assign bus.done         = state_q == DONE;
    assign bus.error        = state_q == ERR;
    assign bus.imem_addr    = addr_q;
    assign bus.imem_wdata   = wdata_q;
    assign bus.words_loaded = cnt_q;
    assign n_full           = {bus.s_data, len_q[7:0]};

    // Next-state: header capture, byte-lane assembly, one-cycle write strobe
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE, ERR: state_d = bus.start ? LEN_LO : state_q;
            LEN_LO: begin
                if (bus.s_valid) begin
                    len_d[7:0] = bus.s_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (bus.s_valid) begin
                    len_d   = n_full;
                    idx_d   = '0;
                    addr_d  = '0;
                    cnt_d   = '0;
                    state_d = n_full == 16'd0 ? DONE : 32'(n_full) > DEPTH ? ERR : DATA;
                end
            end
            DATA: begin
                if (bus.s_valid) begin
                    wdata_d[{idx_q, 3'b000} +: 8] = bus.s_data;
                    idx_d   = idx_q + 2'd1;
                    state_d = idx_q == 2'd3 ? WRITE : DATA;
                end
            end
            WRITE: begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                cnt_d   = cnt_q + (ADDR_WIDTH + 1)'(1);
                state_d = 17'(cnt_q) + 17'd1 == 17'(len_q) ? DONE : DATA;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any load immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized image loads checked against a byte-stream reference model
module tb_imem_loader;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   ready_in_write = 0;

    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    logic [31:0]   exp_words[$];
    logic [7:0]    img[$];
    logic [7:0]    part[$];

    imem_loader_if #(.ADDR_WIDTH(AW)) bus();
    imem_loader #(.ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write log sampled mid-cycle: each strobe cycle contains exactly one falling edge
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
            if (bus.s_ready !== 1'b0) ready_in_write++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_s_ready"}, 32'(bus.s_ready), 0);
        check({tag, "_imem_we"}, 32'(bus.imem_we), 0);
        check({tag, "_imem_addr"}, 32'(bus.imem_addr), 0);
        check({tag, "_imem_wdata"}, 32'(bus.imem_wdata), 0);
        check({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 1);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_error"}, 32'(bus.error), 0);
        check({tag, "_words"}, 32'(bus.words_loaded), 0);
    endtask

    // Reference image: 16-bit LE word count, then each word low byte first
    task automatic build(input int n);
        img = {};
        img.push_back(n[7:0]);
        img.push_back(n[15:8]);
        foreach (exp_words[i]) begin
            img.push_back(exp_words[i][7:0]);
            img.push_back(exp_words[i][15:8]);
            img.push_back(exp_words[i][23:16]);
            img.push_back(exp_words[i][31:24]);
        end
    endtask

    task automatic rand_words(input int n);
        exp_words = {};
        for (int i = 0; i < n; i++) exp_words.push_back($urandom);
    endtask

    // mode 0: valid always; 1: pattern 1,0,0,1; 2: random
    task automatic stream(input logic [7:0] bytes[$], input int mode);
        int   k = 0;
        int   pi = 0;
        int   budget = 0;
        logic v;
        logic rdy;
        while (k < bytes.size() && budget < 5000) begin
            v = mode == 0 ? 1'b1 : mode == 1 ? (pi % 4 == 0 || pi % 4 == 3) : ($urandom % 3 != 0);
            pi++;
            bus.s_valid = v;
            bus.s_data  = v ? bytes[k] : 8'($urandom);
            rdy = bus.s_ready;
            @(posedge clk);
            #1;
            if (v && rdy) k++;
            budget++;
        end
        bus.s_valid = 1'b0;
        if (k != bytes.size()) check("stream_consumed", k, bytes.size());
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(bus.done || bus.error) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("finished", 32'(bus.done | bus.error), 1);
    endtask

    task automatic clear_log();
        wr_addr = {};
        wr_data = {};
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_count"}, wr_data.size(), exp_words.size());
        for (int i = 0; i < exp_words.size() && i < wr_data.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), i % DEPTH);
            check($sformatf("%s_data%0d", tag, i), wr_data[i], exp_words[i]);
        end
    endtask

    task automatic load(input string tag, input int mode);
        clear_log();
        build(exp_words.size());
        pulse_start();
        stream(img, mode);
        wait_end();
        check_writes(tag);
        check({tag, "_words"}, 32'(bus.words_loaded), exp_words.size());
        check({tag, "_addr"}, 32'(bus.imem_addr), exp_words.size() % DEPTH);
        check({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 0);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed two-word image with s_valid held high
        exp_words = '{32'h00500013, 32'h002084B3};
        build(2);
        check("img_bytes", {img[2], img[3], img[4], img[5]}, 32'h13005000);
        clear_log();
        pulse_start();
        check("n2_busy", 32'(bus.busy), 1);
        stream(img, 0);
        wait_end();
        check("n2_latency", cyc - start_cyc, 12);
        check_writes("n2");
        check("n2_done", 32'(bus.done), 1);
        check("n2_cpu_reset", 32'(bus.cpu_reset), 0);
        check("n2_words", 32'(bus.words_loaded), 2);

        // Same image under backpressure, restarting from DONE
        clear_log();
        pulse_start();
        check("bp_cpu_reset_reassert", 32'(bus.cpu_reset), 1);
        check("bp_done_clear", 32'(bus.done), 0);
        stream(img, 1);
        wait_end();
        check_writes("bp");
        check("bp_ready_in_write", ready_in_write, 0);

        // Randomized images and random valid timing
        for (int r = 0; r < 4; r++) begin
            rand_words($urandom_range(1, 12));
            load($sformatf("rnd%0d", r), 2);
        end

        // N=0 completes with no write
        exp_words = {};
        build(0);
        clear_log();
        pulse_start();
        stream(img, 0);
        wait_end();
        check("n0_done", 32'(bus.done), 1);
        check("n0_writes", wr_data.size(), 0);

        // N=257 exceeds depth
        build(257);
        clear_log();
        pulse_start();
        stream(img, 0);
        wait_end();
        @(posedge clk);
        #1;
        check("n257_error", 32'(bus.error), 1);
        check("n257_cpu_reset", 32'(bus.cpu_reset), 1);
        check("n257_s_ready", 32'(bus.s_ready), 0);
        check("n257_done", 32'(bus.done), 0);
        check("n257_writes", wr_data.size(), 0);

        // Restart from ERR; start during the final WRITE must be ignored
        exp_words = '{32'hDEADBEEF};
        build(1);
        clear_log();
        pulse_start();
        check("err_clear", 32'(bus.error), 0);
        check("err_restart_busy", 32'(bus.busy), 1);
        fork
            stream(img, 0);
            begin
                for (int i = 0; i < 50 && bus.imem_we !== 1'b1; i++) begin
                    @(posedge clk);
                    #1;
                end
                bus.start = 1'b1;
                @(posedge clk);
                #1;
                bus.start = 1'b0;
            end
        join
        check("write_start_done", 32'(bus.done), 1);
        @(posedge clk);
        #1;
        check("write_start_still_done", 32'(bus.done), 1);
        check("write_start_busy", 32'(bus.busy), 0);
        check_writes("dead");

        // Reload from DONE overwrites word 0
        exp_words = '{32'h12345678};
        build(1);
        clear_log();
        pulse_start();
        check("reload_cpu_reset", 32'(bus.cpu_reset), 1);
        stream(img, 0);
        wait_end();
        check_writes("reload");
        check("reload_words", 32'(bus.words_loaded), 1);

        // start pulses while busy are ignored
        rand_words(3);
        build(3);
        clear_log();
        pulse_start();
        fork
            stream(img, 0);
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.start = 1'b1;
                repeat (5) @(posedge clk);
                #1;
                bus.start = 1'b0;
            end
        join
        wait_end();
        check_writes("busy_start");
        check("busy_start_words", 32'(bus.words_loaded), 3);

        // Full-depth image: address wraps, count reaches DEPTH
        rand_words(DEPTH);
        load("full", 0);
        check("full_last_addr", 32'(wr_addr[wr_addr.size() - 1]), DEPTH - 1);
        check("full_done", 32'(bus.done), 1);

        // Reset after the second data byte aborts with no write
        rand_words(4);
        build(4);
        part = img[0:3];
        clear_log();
        pulse_start();
        stream(part, 0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("midload");
        check("midload_writes", wr_data.size(), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        load("after_reset", 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
